// File: rtl/dot_accum16_pkg.sv
// Shared types and widths for the dot-product accumulator.
// Imported by dot_accum16 and its saturating adder.
package dot_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CNT_W  = 8;
  localparam int PROD_W = 32;

endpackage : dot_accum_pkg

// File: rtl/dot_accum16_sat_add.sv
// Unsigned ACC_W-bit saturating adder: accumulator plus a zero-extended product.
// Purely combinational; a carry-out clamps the sum to all ones.
module sat_add
  import dot_accum_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  logic [ACC_W:0] wide_sum;

  // One spare bit catches the carry; an all-ones input only stays all ones.
  assign wide_sum = {1'b0, a} + (ACC_W + 1)'(b);
  assign sat      = wide_sum[ACC_W];
  assign sum      = sat ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];

endmodule : sat_add

// File: rtl/dot_accum16.sv
// Accumulates N_TERMS unsigned products into a saturating sum and
// presents it on a valid/ready output, holding it until taken.
module dot_accum16
  import dot_accum_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_t             state_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               ovf_reg;

  logic [ACC_W-1:0]   add_sum;
  logic               add_sat;

  sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (acc_reg),
    .b   (product),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            state_reg <= ACCUM;
          end
        end
        ACCUM: begin
          // in_ready is implied by the state, so in_valid alone is a transfer.
          if (in_valid) begin
            acc_reg   <= add_sum;
            ovf_reg   <= ovf_reg | add_sat;
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST_CNT) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            if (start) begin
              acc_reg   <= '0;
              count_reg <= '0;
              ovf_reg   <= 1'b0;
              state_reg <= ACCUM;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state_reg == ACCUM);
  assign busy      = (state_reg == ACCUM);
  assign out_valid = (state_reg == DONE);
  assign result    = acc_reg;
  assign overflow  = ovf_reg;
  assign count     = count_reg;

endmodule : dot_accum16

// File: tb/tb_dot_accum16.sv
// Scoreboard bench for dot_accum16 with N_TERMS=4, ACC_W=32 so that
// saturation is reachable with a handful of products.
module tb_dot_accum16;
  import dot_accum_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [PROD_W-1:0] product = '0;
  logic              in_ready;
  logic              out_valid;
  logic              overflow;
  logic              busy;
  logic [AW-1:0]     result;
  logic [CNT_W-1:0]  count;

  int vectors = 0;
  int miscompares = 0;
  int txn = 0;

  logic [AW:0]   sb_q[$];
  logic [AW-1:0] m_acc = '0;
  logic          m_ovf = 1'b0;
  int            m_cnt = 0;

  dot_accum16 #(
    .N_TERMS (N),
    .ACC_W   (AW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference for the upstream combinational multiplier.
  function automatic logic [31:0] mult16(input logic [15:0] e1, input logic [15:0] e2);
    return 32'(e1) * 32'(e2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    check("start_busy", busy, 1);
    check("start_count", count, 0);
  endtask

  // One accepted product; the scoreboard gets its entry with the last term.
  task automatic send(input logic [PROD_W-1:0] p);
    logic [AW:0] s;
    check("send_in_ready", in_ready, 1);
    product  = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    s = {1'b0, m_acc} + (AW + 1)'(p);
    if (s[AW]) begin
      m_acc = '1;
      m_ovf = 1'b1;
    end else begin
      m_acc = s[AW-1:0];
    end
    m_cnt++;
    if (m_cnt == N) sb_q.push_back({m_ovf, m_acc});
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    logic [AW:0] exp;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 0, 1);
    end else if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      exp = sb_q.pop_front();
      txn++;
      $display("txn %0d %s: result=%h overflow=%0d count=%0d", txn, tag, result, overflow, count);
      check({tag, "_result"}, result, exp[AW-1:0]);
      check({tag, "_overflow"}, overflow, exp[AW]);
      check({tag, "_count"}, count, N);
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic sum with exact latency.
    do_start();
    send(1); send(2); send(3);
    check("basic_not_yet", out_valid, 0);
    send(4);
    check("basic_latency", out_valid, 1);
    wait_done("basic");
    take();
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);

    // In IDLE a product is ignored.
    product  = 32'd100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("idle_ignore_result", result, 10);
    check("idle_ignore_count", count, N);

    // Multiplier chain with in_valid toggling.
    do_start();
    for (int i = 0; i < N; i++) begin
      send(i < 2 ? mult16(16'h0296, 16'h01C3) : 32'd0);
      check("toggle_count", count, i + 1);
      if (i < N - 1) begin
        tick();
        check("gap_count", count, i + 1);
      end
    end
    wait_done("mult_chain");
    take();

    // Saturation, backpressure, ignored start, then back-to-back restart.
    do_start();
    send(32'hFFFF_FFFF); send(32'h1); send(32'h0); send(32'h2);
    wait_done("saturate");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, m_acc);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start_ignored", out_valid, 1);
    check("done_start_ovf", overflow, 1);
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    model_clear();
    check("b2b_busy", busy, 1);
    check("b2b_count", count, 0);
    check("b2b_overflow", overflow, 0);
    check("b2b_result", result, 0);

    // Start pulsed during ACCUM is ignored.
    send(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("accum_start_count", count, 1);
    check("accum_start_result", result, 5);
    send(6); send(7); send(8);
    wait_done("accum_start");
    take();

    // Reset mid-accumulation aborts at once.
    do_start();
    send(1); send(2);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_count", count, 0);
    check("arst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_idle", out_valid, 0);
    do_start();
    send(9); send(9); send(9); send(9);
    wait_done("after_reset");
    take();

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dot_accum16
